// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port byte-RAM arbiter/serializer.
// Serves whole-word instruction fetches (IF) and 1/2/4-byte loads/stores
// (MEM) over a byte-wide synchronous RAM, returning little-endian results
// with a one-cycle done pulse per requester.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   if_req_i/if_addr_i  IF fetch request (always 4 bytes), held until done
//   if_done_o/if_inst_o IF completion pulse and fetched word
//   mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i
//                       MEM load/store request, held until done
//   mem_done_o/mem_rdata_o MEM completion pulse and zero-extended load data
//   mem_a/mem_dout/mem_wr RAM address, write data, write enable
//   mem_din             RAM read data, one cycle after the address
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_done_o,
    output logic [31:0]       if_inst_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    output logic              mem_wr,
    input  logic [7:0]        mem_din
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;       // latched start address
    logic [2:0]        nbytes;     // latched transfer length (1, 2 or 4)
    logic [2:0]        cyc;        // edges since acceptance
    logic [31:0]       wdata;      // latched store data
    logic [31:0]       rbuf;       // read assembly buffer
    logic [31:0]       rbuf_nxt;
    logic              owner_mem;  // 1 = MEM owns the current transaction
    logic [2:0]        req_len;
    logic [1:0]        cap_idx;

    // Length 2'b10 is treated as a full word.
    always_comb begin
        case (mem_len_i)
            2'b00:   req_len = 3'd1;
            2'b01:   req_len = 3'd2;
            default: req_len = 3'd4;
        endcase
    end

    // Byte i arrives two edges after its address was issued, so at edge
    // cyc the byte landing on mem_din belongs to lane cyc-2. The final byte
    // is merged combinationally so the result can be published on that
    // same edge.
    assign cap_idx = 2'(cyc - 3'd2);

    always_comb begin
        rbuf_nxt = rbuf;
        if (state == READ && cyc >= 3'd2)
            rbuf_nxt[{cap_idx, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            base        <= '0;
            nbytes      <= '0;
            cyc         <= '0;
            wdata       <= '0;
            rbuf        <= '0;
            owner_mem   <= 1'b0;
            if_done_o   <= 1'b0;
            if_inst_o   <= '0;
            mem_done_o  <= 1'b0;
            mem_rdata_o <= '0;
            mem_a       <= '0;
            mem_dout    <= '0;
            mem_wr      <= 1'b0;
        end else begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    // No acceptance while a done pulse is out: the requester
                    // is still dropping its req during that cycle.
                    if (!if_done_o && !mem_done_o && (mem_req_i || if_req_i)) begin
                        cyc  <= 3'd1;
                        rbuf <= '0;
                        if (mem_req_i) begin
                            owner_mem <= 1'b1;
                            base      <= mem_addr_i;
                            nbytes    <= req_len;
                            wdata     <= mem_wdata_i;
                            mem_a     <= mem_addr_i;
                            if (mem_we_i) begin
                                state    <= WRITE;
                                mem_dout <= mem_wdata_i[7:0];
                                mem_wr   <= 1'b1;
                            end else begin
                                state <= READ;
                            end
                        end else begin
                            owner_mem <= 1'b0;
                            base      <= if_addr_i;
                            nbytes    <= 3'd4;
                            mem_a     <= if_addr_i;
                            state     <= READ;
                        end
                    end
                end
                READ: begin
                    cyc  <= cyc + 3'd1;
                    rbuf <= rbuf_nxt;
                    if (cyc < nbytes)
                        mem_a <= base + ADDR_W'(cyc);
                    if (cyc == nbytes + 3'd1) begin
                        state <= IDLE;
                        if (owner_mem) begin
                            mem_done_o  <= 1'b1;
                            mem_rdata_o <= rbuf_nxt;
                        end else begin
                            if_done_o <= 1'b1;
                            if_inst_o <= rbuf_nxt;
                        end
                    end
                end
                WRITE: begin
                    if (cyc == nbytes) begin
                        mem_wr     <= 1'b0;
                        mem_done_o <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        mem_a    <= base + ADDR_W'(cyc);
                        mem_dout <= wdata[{cyc[1:0], 3'b000} +: 8];
                        cyc      <= cyc + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port byte-RAM arbiter and serializer between the instruction-fetch stage, the memory-access stage and the byte-wide RAM.
- Accepts whole-word fetch requests from IF and 1/2/4-byte load/store requests from MEM.
- Issues the individual byte transactions to RAM and assembles/returns little-endian results with a one-cycle done pulse.
- IF no longer sequences bytes itself; it holds a request until done.

Parameters:
ADDR_W, 32, RAM address width (mem_a width; internal byte address arithmetic is modulo 2^ADDR_W)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-low (rst==0 at a rising edge resets)
if_req_i  input  1  IF requests a 4-byte instruction fetch; held until if_done_o
if_addr_i  input  ADDR_W  fetch byte address
if_done_o  output  1  one-cycle pulse: if_inst_o valid
if_inst_o  output  32  fetched instruction, little-endian
mem_req_i  input  1  MEM stage requests load/store; held until mem_done_o
mem_we_i  input  1  1 = store, 0 = load
mem_len_i  input  2  00 = 1B, 01 = 2B, 11 = 4B, 10 treated as 4B
mem_addr_i  input  ADDR_W  start byte address
mem_wdata_i  input  32  store data, byte i = bits [8i+7:8i]
mem_done_o  output  1  one-cycle completion pulse
mem_rdata_o  output  32  load data, zero-extended, little-endian
mem_a  output  ADDR_W  RAM byte address
mem_dout  output  8  RAM write data
mem_wr  output  1  RAM write enable
mem_din  input  8  RAM read data, valid the cycle after the RAM samples mem_a

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Byte counters 0.
  - Reset mid-transaction aborts with no done pulse; partially written bytes stay in RAM.
- States:
  - IDLE: no transaction in progress.
  - READ: issue N address bytes, capture N data bytes.
  - WRITE: issue N bytes.
- Arbitration:
  - Only in IDLE, and only when neither done output is high that cycle.
  - MEM beats IF on simultaneous requests.
  - The grant is held until done; there is no preemption.
  - IF fetch is always READ, N=4. MEM uses N from mem_len_i.
- Requesters must drop req in the cycle their done is high. A req still high the cycle after done starts a new transaction.
- READ timing (acceptance edge E0):
  - After edge E(i), i=0..N-1: mem_a = addr+i, mem_wr = 0.
  - RAM returns byte i on mem_din, captured at E(i+2) into bits [8i+7:8i].
  - Done pulse and result driven after E(N+1), so a 4-byte fetch is done 5 cycles after acceptance.
  - Unused upper bytes are 0.
- WRITE timing:
  - After E(i): mem_a = addr+i, mem_dout = wdata byte i, mem_wr = 1.
  - mem_done_o is driven after E(N).
  - mem_wr returns to 0 after E(N).
- When no write is in progress, mem_wr = 0. mem_a holds its last value.
- if_inst_o and mem_rdata_o hold their value until the next completion of the same requester.
- Address wraps modulo 2^ADDR_W, e.g. addr = all-ones + 1 = 0.
- Request inputs (addr, len, we, wdata) are latched at acceptance. Later changes are ignored.
- IF req arriving during a MEM transaction waits, and is accepted at the first legal IDLE edge after mem_done_o.

Test Plan:
- Reset held low 3 cycles, then released, no req -> all outputs 0, mem_wr never 1.
- RAM[0x100..0x103] = 13,05,50,00; if_req_i with addr 0x100 -> mem_a 0x100..0x103 on consecutive cycles; if_done_o pulses exactly 5 cycles after acceptance with if_inst_o = 0x00500513.
- mem_req_i store, len 11, addr 0x20, wdata 0xDEADBEEF -> mem_wr high 4 cycles with mem_dout EF,BE,AD,DE at 0x20..0x23; mem_done_o after 4 cycles. A following 2-byte load at 0x22 -> mem_rdata_o = 0x0000DEAD after 3 cycles.
- if_req_i and mem_req_i (1-byte load) asserted in the same cycle -> MEM served first. mem_done_o, then the IF fetch starts at the next legal edge; if_done_o follows with correct data.
- rst driven low during byte 2 of a 4-byte store -> no done pulse, outputs 0 next cycle; RAM holds only bytes 0..1 of the new data.
- 4-byte fetch at addr 0xFFFFFFFE (ADDR_W = 32) -> mem_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
